iw_decoder_movwide: RTL
=======================

// Module: iw_decoder_movwide
// PURPOSE
//  Sequenced decoder for the move-wide family: MOVZ, MOVN and MOVK.
//  Latches one instruction word and emits one 33-bit control word per cycle, plus the K constant.
//  MOVK takes two cycles (clear the halfword, then OR in the immediate); MOVZ and MOVN take one.
//  Sits in the control unit beside the other IW decoders; the control unit muxes cw/k onto the datapath.
// PARAMETERS
//  DATA_WIDTH  64  datapath/K width; 32 or 64. 32 limits hw shift to 0 or 1.
//  IMM_WIDTH   16  immediate halfword width; DATA_WIDTH must be a multiple of IMM_WIDTH.
// PORTS
//  clock       in   1           rising-edge clock
//  reset       in   1           asynchronous, active-high
//  start       in   1           request: decode I (accepted only when ready=1)
//  flush       in   1           synchronous abort; highest priority after reset
//  I           in   32          instruction word {op[8:0], hw[1:0], imm[15:0], Rd[4:0]}
//  ready       out  1           able to accept start this cycle
//  cw          out  33          control word {alu_en, alu_bs, alu_fs[4:0], rf_b_en, rf_sa, rf_sb,
//                               rf_da, rf_w, ram_en, ram_w, pc_en, pc_fs[1:0], pc_is, status_ld, next_state[1:0]}
//  k           out  DATA_WIDTH  ALU B constant
//  done        out  1           final control word of the instruction is on cw this cycle
//  illegal     out  1           one-cycle pulse: the accepted I is not a legal move-wide
// BEHAVIOUR
//  States: IDLE, EXEC, KSET. I, op, hw and Rd are latched when start && ready.
//  ready = (state==IDLE) || done. Back-to-back issue is allowed, one instruction per 1-2 cycles.
//  IDLE:
//    - cw = NOP: alu_en=0, rf_w=0, ram_*=0, pc_en=0, pc_fs=00 (hold), status_ld=0, next_state=00
//    - k=0, done=0
//  Accept -> EXEC next cycle. Latency from start to first cw is 1 cycle.
//  Opcode decode: MOVN=9'b100100101, MOVZ=9'b110100101, MOVK=9'b111100101.
//  Shift amount sh = hw*IMM_WIDTH. K values are zero-filled, unlike the 1-filled K of the old MOVZ decoder.
//  EXEC, common fields:
//    - alu_en=1, alu_bs=1, rf_da=Rd, rf_w=1, rf_b_en=0
//    - rf_sb=31 (don't care), pc_is=0, status_ld=0
//  EXEC, per opcode:
//    - MOVZ: rf_sa=31, alu_fs=001_00 (A|B), k=imm<<sh. done=1, pc_fs=01, next_state=00.
//    - MOVN: rf_sa=31, alu_fs=001_10 (A|~B), k=imm<<sh, so Rd = ~(imm<<sh). done=1, pc_fs=01, next_state=00.
//    - MOVK: rf_sa=Rd, alu_fs=000_00 (A&B), k=~({IMM_WIDTH{1}}<<sh). done=0, pc_fs=00, next_state=01 -> KSET.
//  KSET (MOVK second cycle):
//    - rf_sa=Rd, alu_fs=001_00, k=imm<<sh, rf_w=1, done=1, pc_fs=01, next_state=00.
//  Illegal instruction: an op outside the three opcodes, or DATA_WIDTH=32 with hw[1]=1.
//    - EXEC emits NOP fields except pc_fs=01 (skip the instruction)
//    - illegal=1, done=1; the register file is never written
//  After done: -> EXEC if start is accepted the same cycle, else -> IDLE.
//  start while not ready: ignored, with no effect on the latched I.
//  flush: next state IDLE and latched op cleared. An in-flight MOVK aborted after EXEC leaves Rd partially cleared; the issuer re-executes it.
//  reset (asynchronous, any state): state=IDLE, cw=NOP, k=0, done=0, illegal=0, ready=1 immediately.
//  All outputs are decoded from registered state and latched fields only; there is no combinational path from I to cw/k.
// TESTING
//  T1 MOVZ X3,#0xBEEF,LSL#32 (hw=2):
//     - 1 cycle later: k=64'h0000_BEEF_0000_0000, rf_sa=31, alu_fs=00100, rf_da=3, rf_w=1, done=1, pc_fs=01
//  T2 MOVN X5,#0x0001 (hw=0):
//     - k=64'h1, alu_fs=00110, rf_sa=31, done=1; a datapath model yields X5=64'hFFFF_FFFF_FFFF_FFFE
//  T3 MOVK X7,#0x1234,LSL#16 with X7=64'hAAAA_AAAA_AAAA_AAAA:
//     - cycle 1: k=64'hFFFF_FFFF_0000_FFFF, alu_fs=00000, rf_sa=7, done=0, pc_fs=00
//     - cycle 2: k=64'h0000_0000_1234_0000, alu_fs=00100, done=1, pc_fs=01
//     - final X7=64'hAAAA_AAAA_1234_AAAA
//  T4 back-to-back: MOVK, with MOVZ held on start throughout:
//     - MOVZ is accepted on the MOVK done cycle, so its cw appears the next cycle
//     - ready=0 only during MOVK EXEC; total 3 cycles for both
//  T5 op=9'h1FF, then (DATA_WIDTH=32) MOVZ with hw=3:
//     - each gives illegal=1, done=1, rf_w=0, pc_fs=01 for one cycle
//  T6 reset asserted asynchronously mid-MOVK (between EXEC and KSET):
//     - cw=NOP and ready=1 before the next edge; KSET never issued
//     - repeat with flush: same result, one edge later

Source files
------------

// File: rtl/iw_decoder_movwide_if.sv
// Issue/decode bundle between the control unit and the move-wide decoder.
// The control unit drives the request side (master); the decoder answers (slave).
interface iw_decoder_movwide_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  start;
   logic                  flush;
   logic [31:0]           I;
   logic                  ready;
   logic [32:0]           cw;
   logic [DATA_WIDTH-1:0] k;
   logic                  done;
   logic                  illegal;

   modport master (
      output start, flush, I,
      input  ready, cw, k, done, illegal
   );

   modport slave (
      input  start, flush, I,
      output ready, cw, k, done, illegal
   );
endinterface

// File: rtl/iw_decoder_movwide.sv
// Sequenced decoder for MOVZ / MOVN / MOVK.
// Latches one instruction word on start && ready and emits one control word per
// cycle plus the ALU B constant k. MOVK takes two cycles (clear halfword, then OR
// in the immediate); MOVZ, MOVN and illegal words take one.
// cw/k/done/illegal are decoded from registered state and latched fields only.
module iw_decoder_movwide #(
   parameter int DATA_WIDTH = 64,
   parameter int IMM_WIDTH  = 16
) (
   input logic                clock,
   input logic                reset,
   iw_decoder_movwide_if.slave bus
);

   localparam logic [8:0] OP_MOVN  = 9'b100100101;
   localparam logic [8:0] OP_MOVZ  = 9'b110100101;
   localparam logic [8:0] OP_MOVK  = 9'b111100101;
   localparam int         HW_SLOTS = DATA_WIDTH / IMM_WIDTH;

   localparam logic [4:0] FS_AND   = 5'b000_00;
   localparam logic [4:0] FS_OR    = 5'b001_00;
   localparam logic [4:0] FS_ORN   = 5'b001_10;
   localparam logic [1:0] PC_HOLD  = 2'b00;
   localparam logic [1:0] PC_INC   = 2'b01;
   localparam logic [4:0] XZR      = 5'd31;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_KSET = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  op_q, op_d;
   logic [1:0]  hw_q, hw_d;
   logic [15:0] imm_q, imm_d;
   logic [4:0]  rd_q, rd_d;

   logic                  is_movz, is_movn, is_movk, legal;
   int unsigned           sh;
   logic [DATA_WIDTH-1:0] imm_sh, hw_mask;

   logic                  alu_en, alu_bs, rf_b_en, rf_w;
   logic                  ram_en, ram_w, pc_en, pc_is, status_ld;
   logic [4:0]            alu_fs, rf_sa, rf_sb, rf_da;
   logic [1:0]            pc_fs, next_st;
   logic [DATA_WIDTH-1:0] k;
   logic                  done, illegal, ready, accept;

   // Opcode classification and shifted immediate / halfword mask from latched fields
   always_comb begin
      is_movz = (op_q == OP_MOVZ);
      is_movn = (op_q == OP_MOVN);
      is_movk = (op_q == OP_MOVK);
      legal   = (is_movz || is_movn || is_movk) && (int'(hw_q) < HW_SLOTS);
      sh      = int'(hw_q) * IMM_WIDTH;
      imm_sh  = {{(DATA_WIDTH-16){1'b0}}, imm_q} << sh;
      hw_mask = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, {IMM_WIDTH{1'b1}}} << sh;
   end

   // Control word, K constant and status flags per state; NOP unless overridden
   always_comb begin
      alu_en    = 1'b0;
      alu_bs    = 1'b0;
      alu_fs    = '0;
      rf_b_en   = 1'b0;
      rf_sa     = '0;
      rf_sb     = '0;
      rf_da     = '0;
      rf_w      = 1'b0;
      ram_en    = 1'b0;
      ram_w     = 1'b0;
      pc_en     = 1'b0;
      pc_fs     = PC_HOLD;
      pc_is     = 1'b0;
      status_ld = 1'b0;
      next_st   = 2'b00;
      k         = '0;
      done      = 1'b0;
      illegal   = 1'b0;
      unique case (state_q)
         S_EXEC: begin
            if (!legal) begin
               pc_fs   = PC_INC;
               done    = 1'b1;
               illegal = 1'b1;
            end else begin
               alu_en = 1'b1;
               alu_bs = 1'b1;
               rf_sb  = XZR;
               rf_da  = rd_q;
               rf_w   = 1'b1;
               if (is_movk) begin
                  rf_sa   = rd_q;
                  alu_fs  = FS_AND;
                  k       = ~hw_mask;
                  next_st = 2'b01;
               end else begin
                  rf_sa  = XZR;
                  alu_fs = is_movn ? FS_ORN : FS_OR;
                  k      = imm_sh;
                  pc_fs  = PC_INC;
                  done   = 1'b1;
               end
            end
         end
         S_KSET: begin
            alu_en = 1'b1;
            alu_bs = 1'b1;
            rf_sa  = rd_q;
            rf_sb  = XZR;
            rf_da  = rd_q;
            rf_w   = 1'b1;
            alu_fs = FS_OR;
            k      = imm_sh;
            pc_fs  = PC_INC;
            done   = 1'b1;
         end
         default: ;
      endcase
   end

   assign ready       = (state_q == S_IDLE) || done;
   assign accept      = bus.start && ready && !bus.flush;
   assign bus.ready   = ready;
   assign bus.done    = done;
   assign bus.illegal = illegal;
   assign bus.k       = k;
   assign bus.cw      = {alu_en, alu_bs, alu_fs, rf_b_en, rf_sa, rf_sb, rf_da, rf_w,
                         ram_en, ram_w, pc_en, pc_fs, pc_is, status_ld, next_st};

   // Next state and instruction-field latching; flush overrides any accept
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      hw_d    = hw_q;
      imm_d   = imm_q;
      rd_d    = rd_q;
      if (accept) begin
         op_d  = bus.I[31:23];
         hw_d  = bus.I[22:21];
         imm_d = bus.I[20:5];
         rd_d  = bus.I[4:0];
      end
      unique case (state_q)
         S_IDLE:  state_d = accept ? S_EXEC : S_IDLE;
         S_EXEC:  state_d = (legal && is_movk) ? S_KSET : (accept ? S_EXEC : S_IDLE);
         S_KSET:  state_d = accept ? S_EXEC : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (bus.flush) begin
         state_d = S_IDLE;
         op_d    = '0;
      end
   end

   // State and latched instruction fields
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         hw_q    <= '0;
         imm_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         hw_q    <= hw_d;
         imm_q   <= imm_d;
         rd_q    <= rd_d;
      end
   end

endmodule
